// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI daisy-chain responder.
package spi_pkg;

    localparam int SPI_WIDTH       = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a rise/fall detector on the synchronised output.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    // Edge is acted on the clk after it reaches the last stage: STAGES+1 latency.
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_daisy_slave.sv
// SPI mode-0 daisy-chain link oversampled in the clk domain.
// Optional: SPI_SLV_FRAME_ERR_EN adds a frame_err pulse for partial or empty frames.
module spi_daisy_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             busy
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    spi_slv_state_t state, state_nxt;

    logic             sclk_s, sclk_rise, sclk_fall;
    logic             cs_s, cs_rise, cs_fall;
    logic             mosi_s;
    logic [1:0]       mosi_edge_unused;
    logic             sclk_s_unused, cs_s_unused;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi),
        .q(mosi_s), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
    );

    assign sclk_s_unused = sclk_s;
    assign cs_s_unused   = cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_SLV_FRAME_ERR_EN
    logic seen_rise, err_q;
`endif

    // cs rise takes priority over any sclk edge seen in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            miso    <= 1'b0;
            dout    <= '0;
`ifdef SPI_SLV_FRAME_ERR_EN
            seen_rise <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg   <= tx_data;
                        bit_cnt <= '0;
                        miso    <= tx_data[WIDTH-1];
`ifdef SPI_SLV_FRAME_ERR_EN
                        seen_rise <= 1'b0;
`endif
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        dout <= shreg;
`ifdef SPI_SLV_FRAME_ERR_EN
                        err_q <= (bit_cnt != '0) || !seen_rise;
`endif
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[WIDTH-2:0], mosi_s};
                        bit_cnt <= (bit_cnt == CW'(WIDTH-1)) ? '0 : bit_cnt + 1'b1;
`ifdef SPI_SLV_FRAME_ERR_EN
                        seen_rise <= 1'b1;
`endif
                    end else if (sclk_fall) begin
                        miso <= shreg[WIDTH-1];
                    end
                end
                DONE: begin
                    miso <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
                    err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
`ifdef SPI_SLV_FRAME_ERR_EN
        frame_err = (state == DONE) && err_q;
`endif
    end

endmodule

// File: tb/tb_spi_daisy_slave.sv
// Randomised self-checking bench for spi_daisy_slave; the model is a bit queue per link.
module tb_spi_daisy_slave;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk = 1'b0;
    logic         cs = 1'b1;
    logic         mosi = 1'b0;
    logic [W-1:0] tx0 = '0, tx1 = '0;
    logic         miso0, miso1, done0, done1, busy0, busy1;
    logic [W-1:0] dout0, dout1;
`ifdef SPI_SLV_FRAME_ERR_EN
    logic         fe0, fe1;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_daisy_slave u0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .tx_data(tx0),
        .miso(miso0), .dout(dout0), .done(done0), .busy(busy0)
`ifdef SPI_SLV_FRAME_ERR_EN
        , .frame_err(fe0)
`endif
    );

    spi_daisy_slave u1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(miso0), .tx_data(tx1),
        .miso(miso1), .dout(dout1), .done(done1), .busy(busy1)
`ifdef SPI_SLV_FRAME_ERR_EN
        , .frame_err(fe1)
`endif
    );

    always @(negedge clk) if (done0) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The word a link holds is simply the last W bits that entered its shift queue.
    function automatic logic [W-1:0] last_word(input logic q[$]);
        logic [W-1:0] w;
        for (int j = 0; j < W; j++) w[j] = q[q.size()-1-j];
        return w;
    endfunction

    task automatic wait_done(input string tag, input logic [W-1:0] exp0, input logic [W-1:0] exp1,
                             input logic chk1, input logic exp_fe);
        logic found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wait_clks(1);
            if (done0) begin found = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, found, 1'b1);
        if (found) begin
            chk({tag, "_dout0"}, dout0, exp0);
            if (chk1) chk({tag, "_dout1"}, dout1, exp1);
            chk({tag, "_busy_at_done"}, busy0, 1'b1);
`ifdef SPI_SLV_FRAME_ERR_EN
            chk({tag, "_frame_err"}, fe0, exp_fe);
`else
            if (exp_fe) begin end
`endif
            wait_clks(1);
            chk({tag, "_done_1clk"}, done0, 1'b0);
            chk({tag, "_busy_after"}, busy0, 1'b0);
            chk({tag, "_miso_idle"}, miso0, 1'b0);
        end
    endtask

    // Drives one frame into link0; data bits go MSB-first from data[nbits-1].
    task automatic run_frame(input string tag, input logic [W-1:0] tx, input int nbits,
                             input logic [31:0] data, input int half);
        logic q[$];
        logic exp_fe;
        int   cnt0;
        q = {};
        for (int i = W-1; i >= 0; i--) q.push_back(tx[i]);
        for (int i = 0; i < nbits; i++) q.push_back(data[nbits-1-i]);
        cnt0 = done_cnt;
        tx0 = tx;
        wait_clks(1);
        cs = 1'b0;
        mosi = (nbits > 0) ? data[nbits-1] : 1'b0;
        wait_clks(half);
        for (int i = 0; i < nbits; i++) begin
            chk({tag, "_miso"}, miso0, q[i]);
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
            mosi = (i + 1 < nbits) ? data[nbits-2-i] : 1'b0;
            wait_clks(half);
        end
        cs = 1'b1;
        exp_fe = (nbits == 0) || (nbits % W != 0);
        wait_done(tag, last_word(q), '0, 1'b0, exp_fe);
        chk({tag, "_one_done"}, done_cnt - cnt0, 1);
        wait_clks(half);
    endtask

    initial begin
        logic [W-1:0] d_hold;
        int           cnt_hold;
        logic         q0[$], q1[$];
        logic [15:0]  stream;

        wait_clks(3);
        chk("rst_miso", miso0, 1'b0);
        chk("rst_dout", dout0, '0);
        chk("rst_done", done0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;
        wait_clks(4);

        // Single link, known vector.
        run_frame("t2", 8'h5A, 8, 32'hA7, 4);

        // Reset mid-frame after 3 bits.
        tx0 = 8'h3C;
        cs = 1'b0;
        mosi = 1'b1;
        wait_clks(4);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; wait_clks(4);
            sclk = 1'b0; mosi = ~mosi; wait_clks(4);
        end
        chk("t1_busy_before", busy0, 1'b1);
        cnt_hold = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t1_miso", miso0, 1'b0);
        chk("t1_dout", dout0, '0);
        chk("t1_done", done0, 1'b0);
        chk("t1_busy", busy0, 1'b0);
        cs = 1'b1; mosi = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(6);
        chk("t1_no_done", done_cnt - cnt_hold, 0);
        run_frame("t1_clean", $urandom, 8, 32'hC3, 4);

        // Two-link chain over 16 sclk.
        tx0 = $urandom; tx1 = $urandom;
        stream = 16'h1234;
        q0 = {}; q1 = {};
        for (int i = W-1; i >= 0; i--) begin q0.push_back(tx0[i]); q1.push_back(tx1[i]); end
        for (int i = 0; i < 16; i++) q0.push_back(stream[15-i]);
        for (int i = 0; i < 16; i++) q1.push_back(q0[i]);
        wait_clks(1);
        cs = 1'b0; mosi = stream[15];
        wait_clks(4);
        for (int i = 0; i < 16; i++) begin
            chk("t3_miso0", miso0, q0[i]);
            chk("t3_miso1", miso1, q1[i]);
            sclk = 1'b1; wait_clks(4);
            sclk = 1'b0; mosi = (i < 15) ? stream[14-i] : 1'b0; wait_clks(4);
        end
        cs = 1'b1;
        wait_done("t3", last_word(q0), last_word(q1), 1'b1, 1'b0);
        chk("t3_dout0_val", dout0, 8'h34);
        chk("t3_dout1_val", dout1, 8'h12);
        wait_clks(4);

        // sclk activity with cs high is ignored.
        d_hold = dout0;
        cnt_hold = done_cnt;
        for (int i = 0; i < 8; i++) begin
            mosi = $urandom_range(0, 1);
            sclk = 1'b1; wait_clks(4);
            chk("t4_miso", miso0, 1'b0);
            sclk = 1'b0; wait_clks(4);
        end
        chk("t4_dout", dout0, d_hold);
        chk("t4_no_done", done_cnt - cnt_hold, 0);
        chk("t4_busy", busy0, 1'b0);

        // Partial and empty frames.
        run_frame("t5_5bit", $urandom, 5, $urandom, 4);
        run_frame("t5_0bit", $urandom, 0, 32'h0, 4);

        // Minimum sclk phase, back-to-back frames.
        cnt_hold = done_cnt;
        run_frame("t6_ff", $urandom, 8, 32'hFF, 4);
        run_frame("t6_00", $urandom, 8, 32'h00, 4);
        chk("t6_two_done", done_cnt - cnt_hold, 2);

        // Random frames of mixed length and timing.
        for (int n = 0; n < 8; n++) begin
            int nb;
            case ($urandom_range(0, 2))
                0:       nb = 8;
                1:       nb = 16;
                default: nb = $urandom_range(1, 20);
            endcase
            run_frame("rnd", $urandom, nb, $urandom, $urandom_range(4, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
